mixer_i2s_tx: RTL and testbench



---
 rtl/mixer_i2s_pkg.sv | 27 ++
 rtl/mixer_i2s_clkgen.sv | 46 ++++
 rtl/mixer_i2s_tx.sv | 67 ++++++
 tb/tb_mixer_i2s_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mixer_i2s_pkg.sv
// Shared types and constants for the mixer-to-I2S output path.
// stereo_frame_t matches the mixer's output frame layout.
package mixer_i2s_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int FRAME_W   = 32;
  localparam int BIT_CNT_W = 5;

  localparam logic [BIT_CNT_W-1:0] LRCK_LEFT_START  = 5'd31;
  localparam logic [BIT_CNT_W-1:0] LRCK_RIGHT_START = 5'd15;

  typedef struct packed {
    logic [SAMPLE_W-1:0] right;
    logic [SAMPLE_W-1:0] left;
  } stereo_frame_t;

  // Word select for a given bit slot; lrck leads the data by one bclk.
  function automatic logic lrck_for(input logic [BIT_CNT_W-1:0] bit_idx);
    return (bit_idx >= LRCK_RIGHT_START) && (bit_idx < LRCK_LEFT_START);
  endfunction

  // Transmission order is left first, MSB first.
  function automatic logic [FRAME_W-1:0] tx_word(input stereo_frame_t f);
    return {f.left, f.right};
  endfunction

endpackage

// File: rtl/mixer_i2s_clkgen.sv
// Bit clock divider, bit slot counter and word select generation.
// fe / frame_load are strobes for the register update that makes the edge visible.
module mixer_i2s_clkgen
  import mixer_i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic i2s_bclk,
  output logic i2s_lrck,
  output logic fe,
  output logic frame_load
);

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [BIT_CNT_W-1:0] bit_nxt;
  logic                 tc;

  assign tc         = (div_cnt == DIV_LAST);
  assign fe         = tc & i2s_bclk;
  assign bit_nxt    = bit_cnt + BIT_CNT_W'(1);
  assign frame_load = fe & (&bit_cnt);

  // bit_cnt starts at 30 so the first fe lands on slot 31 and the second loads a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= 5'd30;
      i2s_bclk <= 1'b1;
      i2s_lrck <= 1'b1;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DIV_W'(1);
      if (tc) i2s_bclk <= ~i2s_bclk;
      if (fe) begin
        bit_cnt  <= bit_nxt;
        i2s_lrck <= lrck_for(bit_nxt);
      end
    end
  end

endmodule

// File: rtl/mixer_i2s_tx.sv
// Stereo I2S (Philips) transmitter with a one-frame input buffer.
// An empty buffer at a frame boundary sends silence and pulses underrun.
module mixer_i2s_tx
  import mixer_i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] in_data,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic               i2s_bclk,
  output logic               i2s_lrck,
  output logic               i2s_sdata,
  output logic               underrun
);

  stereo_frame_t      buf_q;
  logic               buf_full;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] load_word;
  logic               fe;
  logic               frame_load;
  logic               xfer;

  mixer_i2s_clkgen #(.BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .fe         (fe),
    .frame_load (frame_load)
  );

  assign in_rdy    = ~buf_full;
  assign xfer      = in_vld & in_rdy;
  assign load_word = buf_full ? tx_word(buf_q) : '0;

  // A transfer can only coincide with a load when the buffer was empty,
  // so letting the transfer win keeps the new frame for the next boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q     <= '0;
      buf_full  <= 1'b0;
      shreg     <= '0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= frame_load & ~buf_full;
      if (xfer) begin
        buf_q    <= stereo_frame_t'(in_data);
        buf_full <= 1'b1;
      end else if (frame_load) begin
        buf_full <= 1'b0;
      end
      if (frame_load) begin
        i2s_sdata <= load_word[FRAME_W-1];
        shreg     <= {load_word[FRAME_W-2:0], 1'b0};
      end else if (fe) begin
        i2s_sdata <= shreg[FRAME_W-1];
        shreg     <= {shreg[FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_mixer_i2s_tx.sv
// Directed bench for mixer_i2s_tx: one instance at BCLK_DIV=2, one at BCLK_DIV=1.
// Serial bits are captured at every observed bclk falling edge.
module tb_mixer_i2s_tx;
  import mixer_i2s_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_vld, a_rdy, a_bclk, a_lrck, a_sdata, a_ur;
  logic [31:0] a_data;
  logic        b_rst, b_vld, b_rdy, b_bclk, b_lrck, b_sdata, b_ur;
  logic [31:0] b_data;

  mixer_i2s_tx #(.BCLK_DIV(2)) u_a (
    .clk(clk), .reset(a_rst), .in_data(a_data), .in_vld(a_vld), .in_rdy(a_rdy),
    .i2s_bclk(a_bclk), .i2s_lrck(a_lrck), .i2s_sdata(a_sdata), .underrun(a_ur)
  );

  mixer_i2s_tx #(.BCLK_DIV(1)) u_b (
    .clk(clk), .reset(b_rst), .in_data(b_data), .in_vld(b_vld), .in_rdy(b_rdy),
    .i2s_bclk(b_bclk), .i2s_lrck(b_lrck), .i2s_sdata(b_sdata), .underrun(b_ur)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit a_pb  = 1'b1;
  bit b_pb  = 1'b1;
  bit a_sd[$], a_lr[$], b_sd[$], b_lr[$];
  int a_ft[$], a_ut[$], b_ft[$], b_ut[$];
  bit b_feed = 1'b0;
  int b_idx  = 0;
  logic [31:0] b_frames [3] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h7FFF_8000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One clock: sample both DUTs at the falling clk edge, log fe events, feed DUT b.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (a_pb && a_bclk === 1'b0) begin
      a_sd.push_back(a_sdata); a_lr.push_back(a_lrck); a_ft.push_back(cyc);
    end
    if (a_ur === 1'b1) a_ut.push_back(cyc);
    a_pb = (a_bclk === 1'b1);
    if (b_pb && b_bclk === 1'b0) begin
      b_sd.push_back(b_sdata); b_lr.push_back(b_lrck); b_ft.push_back(cyc);
    end
    if (b_ur === 1'b1) b_ut.push_back(cyc);
    b_pb = (b_bclk === 1'b1);
    if (b_feed) begin
      if (b_rdy === 1'b1 && b_idx < 3) begin
        b_vld = 1'b1; b_data = b_frames[b_idx]; b_idx++;
      end else begin
        b_vld = 1'b0;
      end
    end
  endtask

  task automatic wait_fe(input bit sel_b, input int n, input string tag);
    int guard = 0;
    while (((sel_b ? b_ft.size() : a_ft.size()) < n) && guard < 5000) begin
      tick();
      guard++;
    end
    chk(tag, sel_b ? b_ft.size() : a_ft.size(), n);
  endtask

  task automatic push_a(input logic [31:0] d);
    int guard = 0;
    while (a_rdy !== 1'b1 && guard < 1000) begin
      tick();
      guard++;
    end
    chk("push_rdy", a_rdy, 1);
    a_vld = 1'b1; a_data = d;
    tick();
    a_vld = 1'b0;
  endtask

  // 32 captured bits starting at fe index 'first', first capture in the MSB.
  function automatic logic [31:0] word_of(input bit sel_b, input bit lr, input int first);
    logic [31:0] w;
    bit v;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      if (sel_b) v = lr ? b_lr[first+k] : b_sd[first+k];
      else       v = lr ? a_lr[first+k] : a_sd[first+k];
      w = {w[30:0], v};
    end
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    int c0, t;
    bit any;
    a_rst = 1'b1; a_vld = 1'b0; a_data = '0;
    b_rst = 1'b1; b_vld = 1'b0; b_data = '0;
    repeat (3) tick();
    chk("a_reset_outs", {a_bclk, a_lrck, a_sdata, a_ur, a_rdy}, 5'b11001);

    // single frame pushed right after reset
    a_rst = 1'b0; a_vld = 1'b1; a_data = 32'h8001_1234; c0 = cyc;
    tick();
    chk("a_take_f1", a_rdy, 0);
    a_vld = 1'b0;
    wait_fe(0, 33, "a_wait_f1");
    chk("a_first_fe", a_ft[0] - c0, 2);
    chk("a_fe0_lrck", a_lr[0], 0);
    chk("a_bclk_period", a_ft[2] - a_ft[1], 4);
    chk("a_f1_data", word_of(0, 0, 1), 32'h1234_8001);
    chk("a_f1_lrck", word_of(0, 1, 1), 32'h0001_FFFE);
    chk("a_f1_no_ur", a_ut.size(), 0);

    // three frames of underrun
    wait_fe(0, 129, "a_wait_ur");
    any = 1'b0;
    for (int k = 33; k < 129; k++) any |= a_sd[k];
    chk("a_ur_silence", any, 0);
    chk("a_ur_count", a_ut.size(), 3);
    chk("a_ur_spacing1", a_ut[1] - a_ut[0], 128);
    chk("a_ur_spacing2", a_ut[2] - a_ut[1], 128);
    chk("a_ur_at_load", a_ut[0], a_ft[33]);

    // backpressure with in_vld held high
    a_vld = 1'b1; a_data = 32'hAAAA_5555;
    tick();
    chk("bp_take_a", a_rdy, 0);
    a_data = 32'h0F0F_F0F0;
    t = 0;
    while (a_rdy !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    chk("bp_rdy_at_load", cyc, a_ft[129]);
    tick();
    chk("bp_take_b", a_rdy, 0);
    a_vld = 1'b0;
    wait_fe(0, 193, "a_wait_bp");
    chk("bp_frame_a", word_of(0, 0, 129), 32'h5555_AAAA);
    chk("bp_frame_b", word_of(0, 0, 161), 32'hF0F0_0F0F);
    chk("bp_no_ur", a_ut.size(), 3);

    // reset at bit 20 of a frame with the buffer full
    push_a(32'h1357_2468);
    push_a(32'hCAFE_BABE);
    wait_fe(0, 214, "a_wait_mid");
    a_rst = 1'b1; a_vld = 1'b0;
    tick();
    chk("mid_reset_outs", {a_bclk, a_lrck, a_sdata, a_ur, a_rdy}, 5'b11001);
    w = '0;
    for (int k = 0; k < 21; k++) w = {w[30:0], a_sd[193+k]};
    chk("mid_partial", w, 32'h2468_1357 >> 11);
    a_rst = 1'b0; c0 = cyc;
    a_sd.delete(); a_lr.delete(); a_ft.delete(); a_ut.delete();
    wait_fe(0, 2, "a_wait_post");
    chk("post_first_fe", a_ft[0] - c0, 2);
    chk("post_ur_count", a_ut.size(), 1);
    chk("post_ur_at_load", a_ut[0], a_ft[1]);
    chk("post_sdata", a_sd[1], 0);

    // minimum divider, continuous frames
    b_rst = 1'b0; b_feed = 1'b1; c0 = cyc;
    wait_fe(1, 97, "b_wait");
    chk("b_first_fe", b_ft[0] - c0, 1);
    chk("b_bclk_period", b_ft[2] - b_ft[1], 2);
    chk("b_frame_period", b_ft[33] - b_ft[1], 64);
    chk("b_f0_data", word_of(1, 0, 1), 32'h5678_1234);
    chk("b_f1_data", word_of(1, 0, 33), 32'hBEEF_DEAD);
    chk("b_f2_data", word_of(1, 0, 65), 32'h8000_7FFF);
    chk("b_f1_lrck", word_of(1, 1, 33), 32'h0001_FFFE);
    chk("b_no_ur", b_ut.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
